// File: rtl/weight_buffer_bank.sv
// -----------------------------------------------------------------------------
// weight_buffer_bank
//
// Per-filter weight storage sitting between the AXI weight stream and the
// convolution engine. Beats of two elements are written into the filter slot
// picked by the one-hot weight_en. Each slot keeps a fill count. On rd_start
// the stored kernel is replayed one element index per cycle, with element e of
// every active filter presented side by side on w_data.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   weight_en        one-hot filter select for the load path
//   weight_dim       elements per filter (clamped to DEPTH)
//   num_filt         number of active filters (1..N_FILT)
//   clear            synchronous flush of fill counts and replay state
//   s_valid/s_ready  load handshake, s_data holds two elements (low = earlier)
//   rd_start         request one kernel replay
//   w_valid/w_ready  replay handshake, w_data is element e of every filter
//   w_last           current element is the final one of the kernel
//   rd_done          one-cycle pulse after the final element is accepted
//   weights_ready    every active filter holds weight_dim elements
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module weight_buffer_bank #(
   parameter int DATA_W = 16,
   parameter int N_FILT = 32,
   parameter int DEPTH  = 32
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic [N_FILT-1:0]          weight_en,
   input  logic [5:0]                 weight_dim,
   input  logic [5:0]                 num_filt,
   input  logic                       clear,
   input  logic                       s_valid,
   input  logic [2*DATA_W-1:0]        s_data,
   output logic                       s_ready,
   input  logic                       rd_start,
   output logic                       w_valid,
   input  logic                       w_ready,
   output logic [N_FILT*DATA_W-1:0]   w_data,
   output logic                       w_last,
   output logic                       rd_done,
   output logic                       weights_ready
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [5:0] DEPTH_C = 6'(DEPTH);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                      state_reg;
   state_t                      state_next;
   logic [5:0]                  e_reg;
   logic [5:0]                  e_next;
   logic                        w_valid_next;
   logic                        w_last_next;
   logic                        rd_done_next;
   logic                        load_word;
   logic [AW-1:0]               rd_idx;
   logic [N_FILT*DATA_W-1:0]    rd_word;

   logic [5:0]                  dim_eff;
   logic                        en_onehot;
   logic [5:0]                  cnt_arr [N_FILT];
   logic [5:0]                  sel_cnt;
   logic [5:0]                  sel_cnt_inc;
   logic                        wr_fire;
   logic                        wr_pair;
   logic [N_FILT-1:0]           full;

   // Oversized weight_dim values behave as a full slot.
   assign dim_eff = (weight_dim > DEPTH_C) ? DEPTH_C : weight_dim;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
   assign en_onehot = (weight_en != '0) &&
                      ((weight_en & (weight_en - N_FILT'(1))) == '0);

   // Fill count of the selected filter. OR-reduction is exact when
   // weight_en is one-hot, and the result is ignored otherwise.
   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < N_FILT; i++) begin
         if (weight_en[i]) begin
            sel_cnt = sel_cnt | cnt_arr[i];
         end
      end
   end

   assign sel_cnt_inc = sel_cnt + 6'd1;

   // A zero weight_dim makes the compare false, so all writes are refused.
   assign s_ready = (state_reg == IDLE) && en_onehot &&
                    (sel_cnt < dim_eff) && !clear;
   assign wr_fire = s_valid && s_ready;

   // Store the high half only while it still fits inside the kernel; on an
   // odd weight_dim the final beat's high half is dropped.
   assign wr_pair = (sel_cnt_inc < dim_eff);

   // -------------------------------------------------------------------------
   // Per-filter storage, fill count and replay slice
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < N_FILT; gi++) begin : g_filt
      logic [DATA_W-1:0] mem [DEPTH];
      logic [5:0]        cnt_reg;
      logic              wr_here;

      assign wr_here = wr_fire && weight_en[gi];

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            cnt_reg <= '0;
         end else if (clear) begin
            cnt_reg <= '0;
         end else if (wr_here) begin
            cnt_reg <= wr_pair ? (sel_cnt + 6'd2) : sel_cnt_inc;
         end
      end

      // Contents survive clear and reset; the fill count alone says what
      // is valid.
      always_ff @(posedge clk) begin
         if (wr_here) begin
            mem[sel_cnt[AW-1:0]] <= s_data[DATA_W-1:0];
            if (wr_pair) begin
               mem[sel_cnt_inc[AW-1:0]] <= s_data[2*DATA_W-1:DATA_W];
            end
         end
      end

      assign cnt_arr[gi] = cnt_reg;

      // Inactive filters count as full so they do not hold off readiness.
      assign full[gi] = (6'(gi) >= num_filt) || (cnt_reg == dim_eff);

      // Inactive filter slices read as zero on the replay bus.
      assign rd_word[gi*DATA_W +: DATA_W] =
         (6'(gi) < num_filt) ? mem[rd_idx] : '0;
   end

   // -------------------------------------------------------------------------
   // Readiness flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         weights_ready <= 1'b0;
      end else if (clear) begin
         weights_ready <= 1'b0;
      end else begin
         weights_ready <= (dim_eff != 6'd0) && (&full);
      end
   end

   // -------------------------------------------------------------------------
   // Replay state machine: next-state and output-register inputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      e_next       = e_reg;
      w_valid_next = w_valid;
      w_last_next  = w_last;
      rd_done_next = 1'b0;
      load_word    = 1'b0;
      rd_idx       = e_reg[AW-1:0];

      case (state_reg)
         IDLE: begin
            if (rd_start && weights_ready) begin
               state_next   = STREAM;
               e_next       = 6'd0;
               rd_idx       = '0;
               load_word    = 1'b1;
               w_valid_next = 1'b1;
               w_last_next  = (dim_eff == 6'd1);
            end
         end
         STREAM: begin
            if (w_valid && w_ready) begin
               if (e_reg < (dim_eff - 6'd1)) begin
                  e_next      = e_reg + 6'd1;
                  rd_idx      = e_next[AW-1:0];
                  load_word   = 1'b1;
                  // The element being loaded is the last when e+1 == dim-1.
                  w_last_next = ((e_reg + 6'd2) == dim_eff);
               end else begin
                  state_next   = IDLE;
                  w_valid_next = 1'b0;
                  w_last_next  = 1'b0;
                  rd_done_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // clear overrides everything and suppresses the done pulse.
      if (clear) begin
         state_next   = IDLE;
         w_valid_next = 1'b0;
         w_last_next  = 1'b0;
         rd_done_next = 1'b0;
         load_word    = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Replay state machine: registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= IDLE;
         e_reg     <= '0;
         w_valid   <= 1'b0;
         w_last    <= 1'b0;
         rd_done   <= 1'b0;
         w_data    <= '0;
      end else begin
         state_reg <= state_next;
         e_reg     <= e_next;
         w_valid   <= w_valid_next;
         w_last    <= w_last_next;
         rd_done   <= rd_done_next;
         if (load_word) begin
            w_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_weight_buffer_bank.sv
// -----------------------------------------------------------------------------
// tb_weight_buffer_bank
//
// Directed bench for weight_buffer_bank. Loads are mirrored into a small
// model of filters 0 and 1; each replay pushes the expected element words
// into a queue that is popped as the DUT hands elements over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_weight_buffer_bank;

   localparam int DATA_W = 16;
   localparam int N_FILT = 32;
   localparam int DEPTH  = 32;

   logic                      clk = 1'b0;
   logic                      nrst;
   logic [N_FILT-1:0]         weight_en;
   logic [5:0]                weight_dim;
   logic [5:0]                num_filt;
   logic                      clear;
   logic                      s_valid;
   logic [2*DATA_W-1:0]       s_data;
   logic                      s_ready;
   logic                      rd_start;
   logic                      w_valid;
   logic                      w_ready;
   logic [N_FILT*DATA_W-1:0]  w_data;
   logic                      w_last;
   logic                      rd_done;
   logic                      weights_ready;

   weight_buffer_bank #(
      .DATA_W (DATA_W),
      .N_FILT (N_FILT),
      .DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .weight_en     (weight_en),
      .weight_dim    (weight_dim),
      .num_filt      (num_filt),
      .clear         (clear),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .rd_start      (rd_start),
      .w_valid       (w_valid),
      .w_ready       (w_ready),
      .w_data        (w_data),
      .w_last        (w_last),
      .rd_done       (rd_done),
      .weights_ready (weights_ready)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] m [2][DEPTH];
   int          mc [2];
   int          cur_dim;
   int          cur_nf;
   logic [31:0] q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load beat; model updated only when the bench expects acceptance.
   task automatic beat(input int f, input logic [15:0] lo, input logic [15:0] hi,
                       input logic exp_acc);
      weight_en = N_FILT'(1) << f;
      s_data    = {hi, lo};
      s_valid   = 1'b1;
      #1;
      check($sformatf("s_ready_beat_f%0d", f), 32'(s_ready), 32'(exp_acc));
      tick();
      s_valid   = 1'b0;
      weight_en = '0;
      if (exp_acc) begin
         m[f][mc[f]] = lo;
         if (mc[f] + 1 < cur_dim) begin
            m[f][mc[f] + 1] = hi;
            mc[f] += 2;
         end else begin
            mc[f] += 1;
         end
      end
      $display("beat f=%0d lo=%h hi=%h expect_accept=%0d", f, lo, hi, exp_acc);
   endtask

   task automatic push_kernel();
      for (int k = 0; k < cur_dim; k++) begin
         q.push_back({(cur_nf > 1) ? m[1][k] : 16'h0, m[0][k]});
      end
   endtask

   // Runs n_kern replays; rd_start re-issued on each rd_done cycle.
   task automatic run_kernels(input int n_kern, input bit toggle);
      int          done_cnt;
      int          cyc;
      logic [31:0] exp_word;
      done_cnt = 0;
      cyc      = 0;
      q.delete();
      push_kernel();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      while (done_cnt < n_kern && cyc < 200) begin
         w_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         check("weights_ready_hold", 32'(weights_ready), 32'd1);
         if (rd_done) begin
            check("done_valid_low", 32'(w_valid), 32'd0);
            check("done_queue_empty", 32'(q.size()), 32'd0);
            done_cnt++;
            $display("rd_done kernel=%0d cycle=%0d", done_cnt, cyc);
            if (done_cnt < n_kern) begin
               push_kernel();
               rd_start = 1'b1;
            end
         end else begin
            check("valid_streaming", 32'(w_valid), 32'd1);
            check("elem_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               exp_word = q[0];
               check("w_data_f0f1", w_data[31:0], exp_word);
               check("w_data_upper_zero", 32'(w_data[N_FILT*DATA_W-1:32] == '0), 32'd1);
               check("w_last", 32'(w_last), 32'(q.size() == 1));
               if (w_ready && w_valid) begin
                  void'(q.pop_front());
                  $display("elem accepted data=%h last=%0d", w_data[31:0], w_last);
               end
            end
         end
         tick();
         rd_start = 1'b0;
         cyc++;
      end
      check("kernels_done", 32'(done_cnt), 32'(n_kern));
      check("cycle_count", 32'(cyc),
            toggle ? 32'(2 * cur_dim * n_kern) : 32'((cur_dim + 1) * n_kern));
      check("rd_done_single", 32'(rd_done), 32'd0);
      check("idle_after_done", 32'(w_valid), 32'd0);
   endtask

   initial begin
      nrst       = 1'b0;
      weight_en  = '0;
      weight_dim = 6'd4;
      num_filt   = 6'd2;
      clear      = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      rd_start   = 1'b0;
      w_ready    = 1'b0;
      cur_dim    = 4;
      cur_nf     = 2;
      mc[0]      = 0;
      mc[1]      = 0;

      // Reset values
      tick();
      tick();
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_data", 32'(w_data == '0), 32'd1);
      check("rst_w_last", 32'(w_last), 32'd0);
      check("rst_rd_done", 32'(rd_done), 32'd0);
      check("rst_weights_ready", 32'(weights_ready), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      nrst = 1'b1;
      tick();

      // Reset asserted mid-load
      beat(0, 16'h0AA1, 16'h0AA2, 1'b1);
      weight_en = N_FILT'(1);
      s_data    = 32'h0BB2_0BB1;
      s_valid   = 1'b1;
      #2;
      nrst = 1'b0;
      #1;
      mc[0] = 0;
      check("midrst_cnt0", 32'(dut.cnt_arr[0]), 32'(mc[0]));
      check("midrst_w_valid", 32'(w_valid), 32'd0);
      check("midrst_weights_ready", 32'(weights_ready), 32'd0);
      s_valid   = 1'b0;
      weight_en = '0;
      tick();
      nrst = 1'b1;
      tick();

      // Select check
      s_valid   = 1'b1;
      weight_en = '0;
      #1;
      check("sel_zero_s_ready", 32'(s_ready), 32'd0);
      weight_en = N_FILT'(3);
      #1;
      check("sel_two_hot_s_ready", 32'(s_ready), 32'd0);
      s_valid   = 1'b0;
      weight_en = '0;
      tick();

      // Even load: dim 4, two filters
      beat(0, 16'h1001, 16'h1002, 1'b1);
      beat(0, 16'h1003, 16'h1004, 1'b1);
      beat(1, 16'h2001, 16'h2002, 1'b1);
      beat(1, 16'h2003, 16'h2004, 1'b1);
      check("even_wr_not_yet", 32'(weights_ready), 32'd0);
      tick();
      check("even_wr_set", 32'(weights_ready), 32'd1);
      check("even_cnt1", 32'(dut.cnt_arr[1]), 32'(mc[1]));
      beat(1, 16'h2005, 16'h2006, 1'b0);

      // Back-to-back replays
      run_kernels(3, 1'b0);

      // Clear mid-stream
      w_ready  = 1'b1;
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      tick();
      tick();
      check("clr_elem2", 32'(w_data[15:0]), 32'(m[0][2]));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mc[0] = 0;
      mc[1] = 0;
      check("clr_w_valid", 32'(w_valid), 32'd0);
      check("clr_w_last", 32'(w_last), 32'd0);
      check("clr_weights_ready", 32'(weights_ready), 32'd0);
      check("clr_rd_done", 32'(rd_done), 32'd0);
      tick();
      check("clr_rd_done_late", 32'(rd_done), 32'd0);
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("clr_start_ignored", 32'(w_valid), 32'd0);
      tick();
      check("clr_start_ignored2", 32'(w_valid), 32'd0);

      // Odd load: dim 9, one filter
      weight_dim = 6'd9;
      num_filt   = 6'd1;
      cur_dim    = 9;
      cur_nf     = 1;
      w_ready    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat(0, 16'(16'h3000 + 2 * i), 16'(16'h3001 + 2 * i), 1'b1);
      end
      beat(0, 16'h3008, 16'hDEAD, 1'b1);
      check("odd_cnt0", 32'(dut.cnt_arr[0]), 32'(mc[0]));
      check("odd_cnt0_is_9", 32'(mc[0]), 32'd9);
      beat(0, 16'h1111, 16'h2222, 1'b0);
      check("odd_weights_ready", 32'(weights_ready), 32'd1);

      // Replay with backpressure
      run_kernels(1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_buffer_bank.md
# weight_buffer_bank

Per-filter weight storage between the AXI weight stream and the convolution engine. It captures two weight elements per beat into the filter slot selected by the controller's one-hot `weight_en`, and tracks per-filter fill level. On request it replays the stored kernel element by element, presenting element *e* of every filter in parallel to the conv datapath. The stored weights are reused across image windows until explicitly cleared.

## Interface
- `DATA_W`, 16: weight element width.
- `N_FILT`, 32: number of filter slots; equals width of `weight_en`.
- `DEPTH`, 32: maximum elements stored per filter.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `weight_en` in `N_FILT`: one-hot filter select from the CNN controller.
- `weight_dim` in 6: elements per filter. Values above `DEPTH` are treated as `DEPTH`.
- `num_filt` in 6: active filter count, range 1..`N_FILT`.
- `clear` in 1: synchronous flush of all fill counts.
- `s_valid` in 1: weight beat valid.
- `s_data` in 2·`DATA_W`: two elements per beat; `[DATA_W-1:0]` is the earlier element.
- `s_ready` out 1: beat accepted when `s_valid && s_ready`.
- `rd_start` in 1: pulse to begin one kernel replay.
- `w_valid` out 1: `w_data` valid.
- `w_ready` in 1: conv engine accepts the current element.
- `w_data` out `N_FILT`·`DATA_W`: element *e* of filter *f* at slice *f*. Slices for *f* ≥ `num_filt` are 0.
- `w_last` out 1: current element is index `weight_dim`-1.
- `rd_done` out 1: one-cycle pulse after the last element is accepted.
- `weights_ready` out 1: every filter *f* < `num_filt` holds `weight_dim` elements.

## Operation
- Storage: `N_FILT`×`DEPTH`×`DATA_W` register array. Each filter has a fill count `cnt[f]` of 6 bits.
- `weight_dim` and `num_filt` must be held stable from the first write until `clear`. Changing them otherwise is unsupported.
- State machine: IDLE and STREAM.
- **Load path**, IDLE only:
  - `s_ready = (state==IDLE) && onehot(weight_en) && cnt[sel] < weight_dim && !clear`, where *sel* is the set bit of `weight_en`.
  - When `weight_en` is zero or has more than one bit set, `s_ready` is 0 and nothing is written.
  - On an accepted beat:
    - write low half to `mem[sel][cnt]`;
    - if `cnt+1 < weight_dim`, also write high half to `mem[sel][cnt+1]` and add 2 to `cnt`;
    - otherwise add 1 to `cnt` and discard the high half (odd `weight_dim`).
  - `cnt` never exceeds `weight_dim`.
- `weights_ready` is registered: `weight_dim != 0 && cnt[f]==weight_dim` for all *f* < `num_filt`.
- **IDLE → STREAM:** `rd_start && weights_ready && !clear`. The element index *e* is set to 0. `rd_start` is ignored in STREAM or when `weights_ready` is 0.
- **STREAM:**
  - Output registers `w_data`, `w_valid` and `w_last` hold element *e*.
  - On `w_valid && w_ready`:
    - if *e* < `weight_dim`-1, advance *e* and load the next element;
    - else drop `w_valid`, return to IDLE, and pulse `rd_done`.
  - With `w_ready` low, all outputs hold.
- **`clear`** has highest priority in every state:
  - next cycle: all `cnt` become 0, state becomes IDLE, `w_valid`, `w_last` and `weights_ready` become 0;
  - `rd_done` does not pulse;
  - memory contents are not erased.
- `weight_dim` == 0: `weights_ready` stays 0 and all writes are refused.

## Timing
- Reset values: state IDLE, all `cnt` 0, `w_valid` 0, `w_data` 0, `w_last` 0, `rd_done` 0, `weights_ready` 0. `s_ready` is 0 because its combinational inputs are in reset.
- `s_ready` is combinational from `weight_en`, `cnt`, state and `clear`. A write lands at the clock edge; `cnt` is visible the next cycle.
- Back-to-back beats to the same filter are allowed at one per cycle.
- `weights_ready` rises one cycle after the completing write.
- Replay latency: `rd_start` sampled at edge *T* gives `w_valid`=1 with element 0 after edge *T*.
- Throughput is one element per cycle with `w_ready` held high.
- For `weight_dim`=*D* with `w_ready` held high:
  - elements occupy *D* consecutive cycles;
  - `w_last` is high on the *D*th cycle;
  - `rd_done` is high on the following cycle, with `w_valid` 0.
- `rd_start` on the same cycle as `rd_done` starts a new replay: back-to-back kernels with a one-cycle bubble.
- Asynchronous reset mid-stream returns to reset values immediately. Stored weights are then considered invalid because `cnt` is 0.

## Test plan
- **Reset and select check:** assert `nrst`=0 mid-load, then release.
  - Expect all outputs at reset values and `weights_ready`=0.
  - With `weight_en`=0 or 0x3, `s_ready` must stay 0.
- **Even load:** `num_filt`=2, `weight_dim`=4, two beats per filter, filter 0 then filter 1.
  - Expect `weights_ready`=1 one cycle after the 4th beat.
  - Expect a 5th beat to filter 1 refused (`s_ready`=0).
- **Odd load:** `weight_dim`=9, `num_filt`=1, 5 beats with high half of beat 5 = 0xDEAD.
  - Expect `cnt[0]`=9.
  - Expect 0xDEAD absent from the replay.
- **Replay with backpressure:** after the 9-element load, `rd_start`, `w_ready` toggling 1,0,1,…
  - Expect elements 0..8 in order, each held while `w_ready`=0.
  - Expect `w_last` on element 8 only, then a single `rd_done` pulse.
  - Slices 1..31 must read 0.
- **Back-to-back replays:** `w_ready`=1, `rd_start` asserted on every `rd_done` cycle, 3 replays with `weight_dim`=4.
  - Expect 3×4 elements with exactly one idle cycle between kernels.
  - Expect `weights_ready` to remain 1 throughout.
- **Clear mid-stream:** pulse `clear` at element 2 of a replay.
  - Expect `w_valid`=0 next cycle, no `rd_done`, `weights_ready`=0.
  - `rd_start` must then be ignored until filters are reloaded.
